// File: rtl/msb_normalize.sv
// msb_normalize: multi-cycle left-normalizer driven by a leading-bit index.
// Byte-granular shift first, then the residual 0..7 bit shift.
module msb_normalize #(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [XLEN-1:0]    in_data,
    input  logic [SHAMT_W-1:0] in_msb,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    out_data,
    output logic [SHAMT_W-1:0] out_shamt,
    output logic               out_zero,
    output logic               out_mismatch
);

    generate
        if (XLEN != 32 || SHAMT_W != 5) begin : g_bad_param
            $error("msb_normalize supports only XLEN=32, SHAMT_W=5");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BYTE = 2'd1,
        BIT  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [XLEN-1:0]    data_r;
    logic [SHAMT_W-1:0] shamt_r;
    logic               zero_r;
    logic               mismatch_r;

    logic               accept;
    logic [XLEN-1:0]    in_probe;
    logic               in_is_zero;
    logic               in_bad_msb;
    logic [XLEN-1:0]    byte_shifted;
    logic [XLEN-1:0]    bit_shifted;

    logic               in_ready_nxt;
    logic               out_valid_nxt;
    logic               load_out;

    assign accept = in_valid && in_ready;

    // A correct index leaves exactly the MSB at bit 0 after the right shift.
    assign in_probe   = in_data >> in_msb;
    assign in_is_zero = (in_data == '0);
    assign in_bad_msb = !in_is_zero && (in_probe != XLEN'(1));

    assign byte_shifted = data_r << {shamt_r[4:3], 3'b000};
    assign bit_shifted  = data_r << shamt_r[2:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = BYTE;
                end
            end
            BYTE: state_nxt = BIT;
            BIT:  state_nxt = DONE;
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake flags are computed from the next state so they come straight
    // out of flops with no path from in_valid or out_ready to the outputs.
    always_comb begin
        in_ready_nxt  = 1'b0;
        out_valid_nxt = 1'b0;
        load_out      = 1'b0;
        unique case (1'b1)
            (state_nxt == IDLE): in_ready_nxt = 1'b1;
            (state_nxt == DONE): out_valid_nxt = 1'b1;
            default: ;
        endcase
        if (state == BIT) begin
            load_out = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            in_ready  <= in_ready_nxt;
            out_valid <= out_valid_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_r     <= '0;
            shamt_r    <= '0;
            zero_r     <= 1'b0;
            mismatch_r <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        data_r     <= in_data;
                        shamt_r    <= ~in_msb;
                        zero_r     <= in_is_zero;
                        mismatch_r <= in_bad_msb;
                    end
                end
                BYTE:    data_r <= byte_shifted;
                BIT:     data_r <= bit_shifted;
                default: ;
            endcase
        end
    end

    // Result registers change only on the BIT->DONE edge and hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data     <= '0;
            out_shamt    <= '0;
            out_zero     <= 1'b0;
            out_mismatch <= 1'b0;
        end else if (load_out) begin
            out_data     <= bit_shifted;
            out_shamt    <= shamt_r;
            out_zero     <= zero_r;
            out_mismatch <= mismatch_r;
        end
    end

    a_ready_idle: assert property (
        @(posedge clk) disable iff (rst)
        in_ready == (state == IDLE)
    );

    a_valid_done: assert property (
        @(posedge clk) disable iff (rst)
        out_valid == (state == DONE)
    );

    a_hold: assert property (
        @(posedge clk) disable iff (rst)
        out_valid && !out_ready |=> out_valid && $stable(out_data)
            && $stable(out_shamt)
    );

endmodule

// File: tb/tb_msb_normalize.sv
// tb_msb_normalize: directed vector table plus backpressure and reset
// sequences for the multi-cycle normalizer.
module tb_msb_normalize;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [4:0]  in_msb;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_shamt;
    logic        out_zero;
    logic        out_mismatch;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    msb_normalize dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_msb       (in_msb),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_shamt    (out_shamt),
        .out_zero     (out_zero),
        .out_mismatch (out_mismatch)
    );

    typedef struct {
        logic [31:0] data;
        logic [4:0]  msb;
        logic [31:0] exp_data;
        logic [4:0]  exp_shamt;
        logic        exp_zero;
        logic        exp_mism;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request from IDLE and wait (bounded) for out_valid.
    task automatic run_req(input logic [31:0] d, input logic [4:0] m);
        int n;
        chk("ready_before_req", 32'(in_ready), 32'd1);
        in_data  = d;
        in_msb   = m;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 12) begin
            tick();
            n++;
        end
        chk("latency", 32'(n), 32'd3);
        chk("ready_while_done", 32'(in_ready), 32'd0);
    endtask

    initial begin
        vecs[0] = '{32'h0000_0001, 5'd0,  32'h8000_0000, 5'd31, 1'b0, 1'b0};
        vecs[1] = '{32'h00F0_0000, 5'd23, 32'hF000_0000, 5'd8,  1'b0, 1'b0};
        vecs[2] = '{32'h8000_0000, 5'd31, 32'h8000_0000, 5'd0,  1'b0, 1'b0};
        vecs[3] = '{32'h0000_0000, 5'd0,  32'h0000_0000, 5'd31, 1'b1, 1'b0};
        vecs[4] = '{32'h0000_0300, 5'd8,  32'h8000_0000, 5'd23, 1'b0, 1'b1};
        vecs[5] = '{32'h1234_5678, 5'd28, 32'h91A2_B3C0, 5'd3,  1'b0, 1'b0};
        vecs[6] = '{32'h0000_ABCD, 5'd15, 32'hABCD_0000, 5'd16, 1'b0, 1'b0};
        vecs[7] = '{32'h0000_0100, 5'd7,  32'h0000_0000, 5'd24, 1'b0, 1'b1};
        vecs[8] = '{32'h0000_0010, 5'd20, 32'h0000_8000, 5'd11, 1'b0, 1'b1};
        vecs[9] = '{32'h0000_0000, 5'd31, 32'h0000_0000, 5'd0,  1'b1, 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_msb    = '0;
        out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        chk("rst_in_ready",  32'(in_ready),     32'd1);
        chk("rst_out_valid", 32'(out_valid),    32'd0);
        chk("rst_out_data",  out_data,          32'd0);
        chk("rst_out_shamt", 32'(out_shamt),    32'd0);
        chk("rst_out_zero",  32'(out_zero),     32'd0);
        chk("rst_out_mism",  32'(out_mismatch), 32'd0);

        for (int i = 0; i < 10; i++) begin
            run_req(vecs[i].data, vecs[i].msb);
            chk("vec_valid", 32'(out_valid),    32'd1);
            chk("vec_data",  out_data,          vecs[i].exp_data);
            chk("vec_shamt", 32'(out_shamt),    32'(vecs[i].exp_shamt));
            chk("vec_zero",  32'(out_zero),     32'(vecs[i].exp_zero));
            chk("vec_mism",  32'(out_mismatch), 32'(vecs[i].exp_mism));
            tick();
            chk("vec_idle_ready", 32'(in_ready),  32'd1);
            chk("vec_idle_valid", 32'(out_valid), 32'd0);
            chk("vec_hold_data",  out_data,       vecs[i].exp_data);
        end

        // Backpressure: result must hold while stray requests are ignored.
        out_ready = 1'b0;
        run_req(32'h0000_00F0, 5'd7);
        chk("bp_data",  out_data,          32'hF000_0000);
        chk("bp_shamt", 32'(out_shamt),    32'd24);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 32'h0000_0001 << i;
            in_msb   = 5'(i);
            tick();
            chk("bp_valid_hold", 32'(out_valid),    32'd1);
            chk("bp_ready_low",  32'(in_ready),     32'd0);
            chk("bp_data_hold",  out_data,          32'hF000_0000);
            chk("bp_shamt_hold", 32'(out_shamt),    32'd24);
            chk("bp_mism_hold",  32'(out_mismatch), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("bp_release_ready", 32'(in_ready),  32'd1);
        chk("bp_release_valid", 32'(out_valid), 32'd0);
        chk("bp_release_data",  out_data,       32'hF000_0000);
        tick();
        chk("bp_no_stray", 32'(out_valid), 32'd0);

        // Reset while the operation sits in the bit stage.
        in_data  = 32'h0000_0010;
        in_msb   = 5'd4;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        chk("mid_valid_low", 32'(out_valid), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_valid", 32'(out_valid),    32'd0);
        chk("mid_rst_ready", 32'(in_ready),     32'd1);
        chk("mid_rst_data",  out_data,          32'd0);
        chk("mid_rst_shamt", 32'(out_shamt),    32'd0);
        chk("mid_rst_zero",  32'(out_zero),     32'd0);
        chk("mid_rst_mism",  32'(out_mismatch), 32'd0);
        tick();
        chk("mid_rst_quiet", 32'(out_valid), 32'd0);

        run_req(32'h0000_0010, 5'd4);
        chk("post_rst_data",  out_data,          32'h8000_0000);
        chk("post_rst_shamt", 32'(out_shamt),    32'd27);
        chk("post_rst_zero",  32'(out_zero),     32'd0);
        chk("post_rst_mism",  32'(out_mismatch), 32'd0);
        tick();
        chk("post_rst_idle", 32'(in_ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/msb_normalize.md
Name: msb_normalize

Overview:
- Multi-cycle left-normalizer. It is the consumer of an MSB index produced by the team's leading-bit finder.
- Takes a 32-bit operand plus its MSB bit position and shifts the operand left so that the MSB lands at bit 31. Returns the applied shift amount.
- Used ahead of the iterative divider and other fixed-width datapaths that need normalized operands.
- The shift is split into a byte stage and a bit stage. This mirrors the finder's 4x8-bit segmentation and keeps each cycle's logic small.

Parameters:
- XLEN, 32, operand width. Only 32 is supported; elaboration fails otherwise.
- SHAMT_W, 5, shift-amount width. Must equal log2(XLEN). Not to be overridden.

Ports:
- clk  input  1  clock. All logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand request valid.
- in_ready  output  1  block can accept a request.
- in_data  input  32  operand.
- in_msb  input  5  bit index of the operand's most-significant set bit.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_data  output  32  normalized operand.
- out_shamt  output  5  left-shift amount applied, equal to 31-in_msb.
- out_zero  output  1  in_data was 0.
- out_mismatch  output  1  in_msb was inconsistent with nonzero in_data.

Behaviour:
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_data=0, out_shamt=0, out_zero=0, out_mismatch=0.
- rst asserted in any state drops any in-flight operation; the next cycle is IDLE with reset values.
- FSM states are IDLE, BYTE, BIT, DONE. State and all outputs are registered.
- in_ready = (state==IDLE), registered-equivalent. It has no combinational path from in_valid or out_ready.
- IDLE: when in_valid && in_ready, latch the following and go to BYTE. Otherwise stay.
  - data_r = in_data.
  - shamt_r = ~in_msb (5-bit invert, i.e. 31-in_msb).
  - zero_r = (in_data==0).
  - mismatch_r = (in_data!=0) && ((in_data >> in_msb) != 1).
- BYTE: data_r <= data_r << {shamt_r[4:3],3'b000}, shifting by 0/8/16/24. Go to BIT.
- BIT: data_r <= data_r << shamt_r[2:0]. Go to DONE.
- DONE: out_valid=1 with out_data=data_r, out_shamt=shamt_r, out_zero=zero_r, out_mismatch=mismatch_r.
  - On out_ready go to IDLE. out_valid falls and in_ready rises on the next cycle.
  - Without out_ready, hold all outputs stable indefinitely.
- Latency: request accepted at edge T gives out_valid=1 from cycle T+3. Minimum issue interval is 4 cycles with out_ready tied high.
- out_data/out_shamt/out_zero/out_mismatch are updated only on entering DONE. They hold their last values while out_valid=0.
- Zero operand: data stays 0 and out_shamt=~in_msb as supplied. out_zero=1, out_mismatch=0.
- Mismatch: the shift is still performed as commanded. Bits shifted beyond bit 31 are discarded and no saturation is applied. out_mismatch flags the error for the consumer.
- No arithmetic beyond shifts. All shifts are logical and zero-fill.
- in_valid while busy is ignored: no acceptance, no state corruption. The requester must hold the request until in_ready.

Test Plan:
- Reset, then in_data=0x00000001, in_msb=0, out_ready=1. Expect out_valid at T+3, out_data=0x80000000, out_shamt=31, out_zero=0, out_mismatch=0.
- in_data=0x00F00000, in_msb=23. Expect out_data=0xF0000000, out_shamt=8. Then in_data=0x8000_0000, in_msb=31: expect out_data unchanged, out_shamt=0.
- in_data=0, in_msb=0. Expect out_data=0, out_shamt=31, out_zero=1, out_mismatch=0.
- in_data=0x00000300, in_msb=8 (true MSB is 9). Expect out_mismatch=1, out_shamt=23, out_data=0x80000000 (bit 9 is lost).
- Backpressure: out_ready=0 for 5 cycles after out_valid.
  - Expect outputs stable and in_ready=0, with in_valid pulses ignored.
  - When out_ready=1, expect IDLE next cycle and in_ready=1.
- Assert rst during BIT with in_data=0x00000010. Expect out_valid=0 and all outputs 0 on the cycle after rst. A new request then completes normally.
